// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_transmitter
//  Purpose  : Transmit half of the UART. Bytes are written into a small FIFO
//             and sent on tx as: one start bit (16 ticks low), DBITS data
//             bits LSB first (16 ticks each), then a stop period of SBITS
//             ticks high. Timing is counted in 16x-baud ticks that come
//             from the tick generator shared with the receiver.
//
//  Ports    : clk_50Mhz  in   system clock, rising edge
//             rst        in   synchronous active-high reset
//             tick       in   one-clock pulse at 16x baud rate
//             wr_en      in   write strobe, pushes din when not full
//             din        in   [DBITS-1:0] byte to transmit
//             full       out  FIFO full, writes dropped while high
//             fifo_count out  [FIFO_AW:0] bytes queued (excludes shifter)
//             busy       out  high whenever a frame is in progress
//             tx_done    out  one-clock pulse at the end of each stop period
//             tx         out  registered serial line, idle high
//
//  Revision : 1.0  initial release
// ============================================================================
module uart_transmitter #(
    parameter int DBITS   = 8,
    parameter int SBITS   = 16,
    parameter int FIFO_AW = 2
) (
    input  logic               clk_50Mhz,
    input  logic               rst,
    input  logic               tick,
    input  logic               wr_en,
    input  logic [DBITS-1:0]   din,
    output logic               full,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               busy,
    output logic               tx_done,
    output logic               tx
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_DEPTH = 2 ** FIFO_AW;
    // Bit counter must be able to hold DBITS-1; never narrower than one bit.
    localparam int c_BW    = (DBITS > 1) ? $clog2(DBITS) : 1;

    localparam logic [FIFO_AW:0] c_DEPTH_CNT = (FIFO_AW + 1)'(c_DEPTH);
    localparam logic [3:0]       c_TICK_LAST = 4'd15;
    // The tick counter is 4 bits wide, so a stop period is at most 16 ticks.
    localparam logic [3:0]       c_STOP_LAST = 4'(SBITS - 1);
    localparam logic [c_BW-1:0]  c_BIT_LAST  = c_BW'(DBITS - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [DBITS-1:0]   r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;

    logic [1:0]         r_state;
    logic [3:0]         r_tick_cnt;
    logic [c_BW-1:0]    r_bit_cnt;
    logic [DBITS-1:0]   r_shift;
    logic               r_tx;
    logic               r_tx_done;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [DBITS-1:0]   w_head;

    logic [1:0]         w_state_next;
    logic [3:0]         w_tick_next;
    logic [c_BW-1:0]    w_bit_next;
    logic [DBITS-1:0]   w_shift_next;
    logic               w_tx_next;
    logic               w_tx_done_next;

    // ------------------------------------------------------------------------
    // Write-side FIFO
    // ------------------------------------------------------------------------
    assign w_full = (r_count == c_DEPTH_CNT);
    // A write while full is dropped even if a pop frees a slot in the same
    // cycle; the writer is expected to watch full.
    assign w_push = wr_en && !w_full;
    // The FIFO is only drained from IDLE. The clock on which STOP finishes
    // is still in STOP, so there is always at least one IDLE clock between
    // frames.
    assign w_pop  = (r_state == c_IDLE) && (r_count != '0);
    assign w_head = r_mem[r_rd_ptr];

    // Storage is not reset: pointers and count define what is valid.
    always_ff @(posedge clk_50Mhz) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally at the depth (power of two).
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
            r_tx_done  <= w_tx_done_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick_cnt;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;

        case (r_state)
            c_IDLE: begin
                // Any tick on the pop cycle is ignored: the counter starts
                // from zero in START.
                if (w_pop) begin
                    w_shift_next = w_head;
                    w_tick_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = c_START;
                end
            end

            c_START: begin
                if (tick) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_next  = '0;
                        w_state_next = c_DATA;
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end

            c_DATA: begin
                if (tick) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_next  = '0;
                        w_shift_next = r_shift >> 1;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_state_next = c_STOP;
                        end else begin
                            w_bit_next = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end

            c_STOP: begin
                if (tick) begin
                    if (r_tick_cnt == c_STOP_LAST) begin
                        w_tick_next  = '0;
                        w_state_next = c_IDLE;
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------------
    // tx is decoded from the state being entered and then registered, so the
    // line level changes on the same edge as the state and is glitch-free.
    always_comb begin
        w_tx_next      = 1'b1;
        w_tx_done_next = 1'b0;

        case (w_state_next)
            c_START: w_tx_next = 1'b0;
            c_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase

        if ((r_state == c_STOP) && (w_state_next == c_IDLE)) begin
            w_tx_done_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx         = r_tx;
    assign tx_done    = r_tx_done;
    assign busy       = (r_state != c_IDLE);
    assign full       = w_full;
    assign fifo_count = r_count;

endmodule
`default_nettype wire
